uart_cmd_dispatcher: RTL and testbench
======================================

UART_CMD_DISPATCHER -- requirements
Module: uart_cmd_dispatcher

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock and reset ports SHALL be named clk and reset, and no other clock or reset SHALL exist.
REQ-002 Parameter FRAME_BYTES, default 18, SHALL set the bytes per command frame; legal values are 4..64.
REQ-003 Parameter NUM_CH, default 4, SHALL set the number of writable channel registers; legal values are 1..16.
REQ-004 Parameter CMD_BASE, default 8'h41 ("A"), SHALL be the command code of channel 0.
REQ-005 Parameter CHK_EN, default 0, SHALL enable the XOR checksum when set to 1.
REQ-006 Parameter TIMEOUT_CYC, default 1_000_000, SHALL set the inter-byte timeout in clk cycles.
REQ-007 Derived width PB SHALL equal FRAME_BYTES-2 payload bytes.
REQ-008 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts a byte.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts tx_data.
- ch_data  out  NUM_CH*PB*8  channel registers; channel i occupies slice [i*PB*8 +: PB*8].
- ch_wstb  out  NUM_CH  one-cycle pulse on channel write.
- frame_ok  out  1  one-cycle pulse per valid frame.
- err_cnt  out  8  saturating error count.
- busy  out  1  state != IDLE.

Function
REQ-009 A byte SHALL transfer on any clk edge where rx_valid and rx_ready are both 1; a transmit byte likewise transfers when tx_valid and tx_ready are both 1.
REQ-010 The FSM SHALL have the states IDLE, COLLECT, CHECK, DISPATCH and RESP.
- IDLE: the first accepted byte is the command byte; go to COLLECT.
- COLLECT: accept bytes until FRAME_BYTES have been received; go to CHECK.
REQ-011 Frame layout SHALL be: byte 0 = cmd; bytes 1..FRAME_BYTES-2 = payload; byte FRAME_BYTES-1 = terminator, which must equal cmd.
REQ-012 When CHK_EN=1, byte FRAME_BYTES-2 SHALL equal the XOR of bytes 0..FRAME_BYTES-3; it is still stored as the last payload byte.
REQ-013 The first received payload byte SHALL occupy the most-significant byte of the PB*8 payload word.
REQ-014 CHECK SHALL last one cycle; a bad terminator, bad checksum or unknown cmd SHALL increment err_cnt and return to IDLE with no other output change.
REQ-015 For a write, where CMD_BASE <= cmd < CMD_BASE+NUM_CH, DISPATCH SHALL:
- load the payload into channel (cmd-CMD_BASE);
- pulse the matching ch_wstb bit and frame_ok in the same cycle;
- return to IDLE.
REQ-016 The new ch_data SHALL be visible on the cycle after the ch_wstb pulse.
REQ-017 For a read, where cmd == CMD_BASE+NUM_CH, payload byte 0 SHALL select the channel index.
- Index >= NUM_CH: error, no response.
- Otherwise: pulse frame_ok and enter RESP.
REQ-018 RESP SHALL send the PB bytes of the selected channel MS byte first, then return to IDLE after the last handshake.
REQ-019 In RESP, tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-020 rx_ready SHALL be 1 only in IDLE and COLLECT, so incoming bytes are back-pressured during CHECK, DISPATCH and RESP.
REQ-021 In COLLECT, TIMEOUT_CYC consecutive cycles without an accepted byte SHALL discard the partial frame, increment err_cnt and return to IDLE.
REQ-022 The timeout counter SHALL clear on every accepted byte.
REQ-023 err_cnt SHALL saturate at 255 and never wrap.
REQ-024 ch_data SHALL change only through DISPATCH writes.

Reset
REQ-025 Reset SHALL take effect immediately and asynchronously, at any point including mid-frame or mid-RESP. It SHALL force:
- state = IDLE;
- all ch_data = 0;
- ch_wstb = 0, frame_ok = 0, tx_valid = 0, tx_data = 0;
- err_cnt = 0, busy = 0;
- rx_ready = 1 once reset is released.
REQ-026 Any partial frame present at reset SHALL be discarded.

Verification (FRAME_BYTES=4, NUM_CH=2, CMD_BASE=8'h41, CHK_EN=0 unless noted)
REQ-027 Write: send 41 12 34 41 -> ch0 = 16'h1234, ch_wstb = 2'b01 for one cycle, frame_ok pulses, err_cnt = 0.
REQ-028 Bad terminator: send 41 12 34 42 -> ch0 unchanged, err_cnt = 1, no ch_wstb or frame_ok pulse.
REQ-029 Read with stall: write 42 AB CD 42, then send 43 01 00 43, holding tx_ready=0 for 5 cycles -> tx_data holds AB, then AB and CD transfer in order, rx_ready = 0 throughout RESP.
REQ-030 Timeout and errors: send 41 12, then idle TIMEOUT_CYC cycles -> err_cnt = 1; a following 41 55 66 41 gives ch0 = 16'h5566; then 300 bad frames -> err_cnt = 255.
REQ-031 Checksum: with CHK_EN=1 and FRAME_BYTES=5, send 41 12 34 67 41 -> ch0 = 24'h123467; the same frame with 66 in place of 67 -> err_cnt increments and ch0 is unchanged.
REQ-032 Reset mid-RESP: assert reset after the first tx byte -> tx_valid = 0 immediately, ch_data = 0, and the next frame is decoded normally.

Source files
------------

// File: rtl/uart_cmd_dispatcher.sv
// Byte-stream command dispatcher: collects fixed-size frames, validates them, then
// writes a channel register or streams a channel register back out.
module uart_cmd_dispatcher #(
    parameter int unsigned FRAME_BYTES = 18,
    parameter int unsigned NUM_CH      = 4,
    parameter logic [7:0]  CMD_BASE    = 8'h41,
    parameter bit          CHK_EN      = 1'b0,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [7:0]                           rx_data,
    input  logic                                 rx_valid,
    output logic                                 rx_ready,
    output logic [7:0]                           tx_data,
    output logic                                 tx_valid,
    input  logic                                 tx_ready,
    output logic [NUM_CH*(FRAME_BYTES-2)*8-1:0]  ch_data,
    output logic [NUM_CH-1:0]                    ch_wstb,
    output logic                                 frame_ok,
    output logic [7:0]                           err_cnt,
    output logic                                 busy
);
    localparam int unsigned PB    = FRAME_BYTES - 2;
    localparam int unsigned PW    = PB * 8;
    localparam int unsigned CNT_W = $clog2(FRAME_BYTES + 1);

    typedef enum logic [2:0] {StIdle, StCollect, StCheck, StDispatch, StResp} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cmd_q, term_q, chk_q, err_q;
    logic [PW-1:0]      payload_q, tx_sr_q, rd_word;
    logic [PW-1:0]      ch_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_q, tx_cnt_q;
    logic [31:0]        to_q;
    logic               rx_fire, tx_fire, err_inc;
    logic               is_write, is_read, chk_ok, frame_good;
    logic [7:0]         rd_idx, wr_idx;

    // Frame decode; everything here is stable once the frame is collected.
    always_comb begin
        is_write   = (cmd_q >= CMD_BASE) && ({1'b0, cmd_q} < ({1'b0, CMD_BASE} + 9'(NUM_CH)));
        is_read    = ({1'b0, cmd_q} == ({1'b0, CMD_BASE} + 9'(NUM_CH)));
        wr_idx     = cmd_q - CMD_BASE;
        rd_idx     = payload_q[PW-1 -: 8];
        chk_ok     = !CHK_EN || (payload_q[7:0] == chk_q);
        frame_good = (term_q == cmd_q) && chk_ok &&
                     (is_write || (is_read && (rd_idx < 8'(NUM_CH))));
        rd_word    = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (rd_idx == 8'(i)) rd_word = ch_q[i];
        end
    end

    // Next-state logic and error-count requests.
    always_comb begin
        state_d = state_q;
        err_inc = 1'b0;
        unique case (state_q)
            StIdle: if (rx_fire) state_d = StCollect;
            StCollect: begin
                if (rx_fire && cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
                    state_d = StCheck;
                end else if (!rx_fire && to_q == TIMEOUT_CYC - 1) begin
                    state_d = StIdle;
                    err_inc = 1'b1;
                end
            end
            StCheck: begin
                if (frame_good) begin
                    state_d = StDispatch;
                end else begin
                    state_d = StIdle;
                    err_inc = 1'b1;
                end
            end
            StDispatch: state_d = is_read ? StResp : StIdle;
            StResp: if (tx_fire && tx_cnt_q == CNT_W'(PB - 1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the state register so reset clears them at once.
    always_comb begin
        rx_ready = (state_q == StIdle) || (state_q == StCollect);
        tx_valid = (state_q == StResp);
        tx_data  = tx_valid ? tx_sr_q[PW-1 -: 8] : 8'h00;
        frame_ok = (state_q == StDispatch);
        busy     = (state_q != StIdle);
        err_cnt  = err_q;
        rx_fire  = rx_valid && rx_ready;
        tx_fire  = tx_valid && tx_ready;
        ch_wstb  = '0;
        ch_data  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            ch_wstb[i]             = frame_ok && is_write && (wr_idx == 8'(i));
            ch_data[i*PW +: PW]    = ch_q[i];
        end
    end

    // State, frame assembly, channel registers and transmit shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            term_q    <= '0;
            chk_q     <= '0;
            err_q     <= '0;
            payload_q <= '0;
            tx_sr_q   <= '0;
            cnt_q     <= '0;
            tx_cnt_q  <= '0;
            to_q      <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) ch_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
            unique case (state_q)
                StIdle: begin
                    if (rx_fire) begin
                        cmd_q <= rx_data;
                        chk_q <= rx_data;
                        cnt_q <= CNT_W'(1);
                        to_q  <= '0;
                    end
                end
                StCollect: begin
                    if (rx_fire) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        to_q  <= '0;
                        // First payload byte ends up in the MS byte after PB shifts.
                        if (cnt_q <= CNT_W'(FRAME_BYTES - 2)) begin
                            payload_q <= {payload_q[PW-9:0], rx_data};
                        end
                        if (cnt_q <= CNT_W'(FRAME_BYTES - 3)) chk_q <= chk_q ^ rx_data;
                        if (cnt_q == CNT_W'(FRAME_BYTES - 1)) term_q <= rx_data;
                    end else begin
                        to_q <= to_q + 32'd1;
                    end
                end
                StDispatch: begin
                    for (int i = 0; i < int'(NUM_CH); i++) begin
                        if (is_write && wr_idx == 8'(i)) ch_q[i] <= payload_q;
                    end
                    if (is_read) begin
                        tx_sr_q  <= rd_word;
                        tx_cnt_q <= '0;
                    end
                end
                StResp: begin
                    if (tx_fire) begin
                        tx_sr_q  <= tx_sr_q << 8;
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Self-checking bench: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_cmd_dispatcher;
    localparam int T = 40;

    logic        clk = 0, reset = 1;
    logic [7:0]  rx_data_a = 0, rx_data_b = 0;
    logic        rx_valid_a = 0, rx_valid_b = 0, tx_ready = 0;
    logic        rx_ready_a, tx_valid_a, frame_ok_a, busy_a;
    logic [7:0]  tx_data_a, err_a;
    logic [31:0] ch_data_a;
    logic [1:0]  ch_wstb_a;
    logic        rx_ready_b, tx_valid_b, frame_ok_b, busy_b;
    logic [7:0]  tx_data_b, err_b;
    logic [47:0] ch_data_b;
    logic [1:0]  ch_wstb_b;

    int tests_run = 0, tests_failed = 0;
    int wstb0_cnt = 0, wstb1_cnt = 0, fok_cnt = 0;
    logic [7:0]  got_tx[$], exp_tx[$];
    logic [15:0] m_ch[2];
    int          m_err = 0;

    uart_cmd_dispatcher #(.FRAME_BYTES(4), .NUM_CH(2), .CMD_BASE(8'h41), .CHK_EN(1'b0),
                          .TIMEOUT_CYC(T)) dut_a (
        .clk(clk), .reset(reset), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .ch_data(ch_data_a), .ch_wstb(ch_wstb_a), .frame_ok(frame_ok_a), .err_cnt(err_a),
        .busy(busy_a));

    uart_cmd_dispatcher #(.FRAME_BYTES(5), .NUM_CH(2), .CMD_BASE(8'h41), .CHK_EN(1'b1),
                          .TIMEOUT_CYC(T)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(1'b1),
        .ch_data(ch_data_b), .ch_wstb(ch_wstb_b), .frame_ok(frame_ok_b), .err_cnt(err_b),
        .busy(busy_b));

    always #5 clk = ~clk;

    // Observe pulses and transmitted bytes midway between active edges.
    always @(negedge clk) begin
        if (ch_wstb_a[0]) wstb0_cnt++;
        if (ch_wstb_a[1]) wstb1_cnt++;
        if (frame_ok_a) fok_cnt++;
        if (tx_valid_a && tx_ready) got_tx.push_back(tx_data_a);
    end

    // Frame-level reference: what a whole 4-byte frame does to the channels and error count.
    task automatic model_frame(input logic [31:0] f);
        logic [7:0] c, p0, p1, t;
        {c, p0, p1, t} = f;
        if (t != c || c < 8'h41 || c > 8'h43 || (c == 8'h43 && p0 >= 8'd2)) begin
            if (m_err < 255) m_err++;
        end else if (c == 8'h43) begin
            exp_tx.push_back(m_ch[p0[0]][15:8]);
            exp_tx.push_back(m_ch[p0[0]][7:0]);
        end else begin
            m_ch[c - 8'h41] = {p0, p1};
        end
    endtask

    task automatic send_byte_a(input logic [7:0] b);
        int n = 0;
        rx_data_a = b;
        rx_valid_a = 1;
        while (!rx_ready_a && n < 50) begin
            @(posedge clk) #1;
            n++;
        end
        @(posedge clk) #1;
        rx_valid_a = 0;
    endtask

    task automatic send_a(input logic [31:0] f, input bit gaps);
        for (int i = 3; i >= 0; i--) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk) #1;
            send_byte_a(f[i*8 +: 8]);
        end
    endtask

    task automatic send_b(input logic [39:0] f);
        for (int i = 4; i >= 0; i--) begin
            int n = 0;
            rx_data_b = f[i*8 +: 8];
            rx_valid_b = 1;
            while (!rx_ready_b && n < 50) begin
                @(posedge clk) #1;
                n++;
            end
            @(posedge clk) #1;
            rx_valid_b = 0;
        end
    endtask

    task automatic wait_idle_a(input bit rnd);
        int n = 0;
        while ((busy_a || rx_valid_a) && n < 500) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            @(posedge clk) #1;
            n++;
        end
        tx_ready = 1;
        tests_run++;
        if (busy_a) begin
            tests_failed++;
            $display("FAIL idle_wait: busy=%0b after %0d cycles, required 0", busy_a, n);
        end
    endtask

    task automatic check_state_a(input string name);
        tests_run++;
        if (ch_data_a !== {m_ch[1], m_ch[0]} || err_a !== 8'(m_err)) begin
            tests_failed++;
            $display("FAIL %s: ch_data=%h err=%0d, required ch_data=%h err=%0d", name,
                     ch_data_a, err_a, {m_ch[1], m_ch[0]}, m_err);
        end
    endtask

    task automatic check_tx_a(input string name);
        tests_run++;
        if (got_tx != exp_tx) begin
            tests_failed++;
            $display("FAIL %s: tx bytes=%p, required %p", name, got_tx, exp_tx);
        end
        got_tx.delete();
        exp_tx.delete();
    endtask

    task automatic do_reset();
        reset = 1;
        rx_valid_a = 0;
        rx_valid_b = 0;
        tx_ready = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        m_ch[0] = 0;
        m_ch[1] = 0;
        m_err = 0;
        got_tx.delete();
        exp_tx.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (rx_ready_a !== 1 || busy_a !== 0 || tx_valid_a !== 0 || tx_data_a !== 0 ||
            err_a !== 0 || ch_data_a !== 0 || ch_wstb_a !== 0 || frame_ok_a !== 0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy=%b busy=%b txv=%b txd=%h err=%0d ch=%h wstb=%b ok=%b",
                     rx_ready_a, busy_a, tx_valid_a, tx_data_a, err_a, ch_data_a, ch_wstb_a,
                     frame_ok_a);
        end
    endtask

    task automatic test_write();
        int n = 0;
        int f0 = fok_cnt;
        send_a(32'h41123441, 0);
        while (ch_wstb_a == 0 && n < 10) begin
            @(posedge clk) #1;
            n++;
        end
        tests_run++;
        if (ch_wstb_a !== 2'b01 || frame_ok_a !== 1 || ch_data_a[15:0] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL write_pulse: wstb=%b ok=%b ch0=%h, required 01 1 0000",
                     ch_wstb_a, frame_ok_a, ch_data_a[15:0]);
        end
        @(posedge clk) #1;
        model_frame(32'h41123441);
        tests_run++;
        if (ch_wstb_a !== 2'b00 || frame_ok_a !== 0 || ch_data_a[15:0] !== 16'h1234) begin
            tests_failed++;
            $display("FAIL write_after: wstb=%b ok=%b ch0=%h, required 00 0 1234",
                     ch_wstb_a, frame_ok_a, ch_data_a[15:0]);
        end
        wait_idle_a(0);
        check_state_a("write_state");
        tests_run++;
        if (fok_cnt - f0 != 1) begin
            tests_failed++;
            $display("FAIL write_ok_count: frame_ok pulses=%0d, required 1", fok_cnt - f0);
        end
    endtask

    task automatic test_bad_term();
        int w = wstb0_cnt + wstb1_cnt, f = fok_cnt;
        send_a(32'h41123442, 0);
        wait_idle_a(0);
        model_frame(32'h41123442);
        check_state_a("bad_term_state");
        tests_run++;
        if (wstb0_cnt + wstb1_cnt != w || fok_cnt != f) begin
            tests_failed++;
            $display("FAIL bad_term_pulses: wstb=%0d ok=%0d, required 0 0",
                     wstb0_cnt + wstb1_cnt - w, fok_cnt - f);
        end
    endtask

    task automatic test_read_stall();
        int n = 0;
        send_a(32'h42ABCD42, 0);
        wait_idle_a(0);
        model_frame(32'h42ABCD42);
        got_tx.delete();
        tx_ready = 0;
        send_a(32'h43010043, 0);
        model_frame(32'h43010043);
        while (!tx_valid_a && n < 10) begin
            @(posedge clk) #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (tx_valid_a !== 1 || tx_data_a !== 8'hAB || rx_ready_a !== 0) begin
                tests_failed++;
                $display("FAIL read_stall[%0d]: txv=%b txd=%h rdy=%b, required 1 ab 0",
                         i, tx_valid_a, tx_data_a, rx_ready_a);
            end
            @(posedge clk) #1;
        end
        tx_ready = 1;
        @(posedge clk) #1;
        tests_run++;
        if (tx_data_a !== 8'hCD || rx_ready_a !== 0) begin
            tests_failed++;
            $display("FAIL read_second: txd=%h rdy=%b, required cd 0", tx_data_a, rx_ready_a);
        end
        wait_idle_a(0);
        check_tx_a("read_bytes");
        check_state_a("read_state");
    endtask

    task automatic test_timeout();
        send_byte_a(8'h41);
        send_byte_a(8'h12);
        repeat (T - 1) @(posedge clk) #1;
        tests_run++;
        if (busy_a !== 1 || err_a !== 8'(m_err)) begin
            tests_failed++;
            $display("FAIL timeout_early: busy=%b err=%0d, required 1 %0d", busy_a, err_a, m_err);
        end
        @(posedge clk) #1;
        m_err++;
        tests_run++;
        if (busy_a !== 0 || err_a !== 8'(m_err)) begin
            tests_failed++;
            $display("FAIL timeout_fire: busy=%b err=%0d, required 0 %0d", busy_a, err_a, m_err);
        end
        send_a(32'h41556641, 1);
        wait_idle_a(0);
        model_frame(32'h41556641);
        check_state_a("after_timeout");
    endtask

    task automatic test_random();
        logic [7:0] c, p0, p1, t;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: c = 8'h41;
                1: c = 8'h42;
                2: c = 8'h43;
                default: c = 8'($urandom);
            endcase
            p0 = (c == 8'h43) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            p1 = 8'($urandom);
            t = ($urandom_range(0, 4) == 0) ? 8'($urandom) : c;
            send_a({c, p0, p1, t}, 1);
            wait_idle_a(1);
            model_frame({c, p0, p1, t});
            check_state_a("random_state");
            check_tx_a("random_tx");
        end
    endtask

    task automatic test_err_sat();
        for (int k = 0; k < 300; k++) begin
            logic [31:0] f;
            f = {8'h41, 8'($urandom), 8'($urandom), 8'h40};
            send_a(f, 0);
            model_frame(f);
        end
        wait_idle_a(0);
        tests_run++;
        if (err_a !== 8'd255 || m_err != 255) begin
            tests_failed++;
            $display("FAIL err_saturate: err=%0d, required 255", err_a);
        end
        check_state_a("err_sat_state");
    endtask

    task automatic test_checksum();
        int n = 0;
        send_b(40'h4112346741);
        while (busy_b && n < 20) begin
            @(posedge clk) #1;
            n++;
        end
        tests_run++;
        if (ch_data_b[23:0] !== 24'h123467 || err_b !== 0) begin
            tests_failed++;
            $display("FAIL chk_good: ch0=%h err=%0d, required 123467 0", ch_data_b[23:0], err_b);
        end
        send_b(40'h4112346641);
        n = 0;
        while (busy_b && n < 20) begin
            @(posedge clk) #1;
            n++;
        end
        tests_run++;
        if (ch_data_b[23:0] !== 24'h123467 || err_b !== 1) begin
            tests_failed++;
            $display("FAIL chk_bad: ch0=%h err=%0d, required 123467 1", ch_data_b[23:0], err_b);
        end
    endtask

    task automatic test_reset_mid_resp();
        int n = 0;
        send_a(32'h42BEEF42, 0);
        wait_idle_a(0);
        tx_ready = 1;
        send_a(32'h43010043, 0);
        while (!(tx_valid_a && tx_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk) #2;
        reset = 1;
        #1;
        tests_run++;
        if (tx_valid_a !== 0 || ch_data_a !== 0 || busy_a !== 0 || err_a !== 0 ||
            tx_data_a !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_resp: txv=%b txd=%h ch=%h busy=%b err=%0d, required all 0",
                     tx_valid_a, tx_data_a, ch_data_a, busy_a, err_a);
        end
        @(negedge clk);
        reset = 0;
        m_ch[0] = 0;
        m_ch[1] = 0;
        m_err = 0;
        got_tx.delete();
        exp_tx.delete();
        @(posedge clk) #1;
        send_a(32'h41C0DE41, 0);
        wait_idle_a(0);
        model_frame(32'h41C0DE41);
        check_state_a("post_reset_frame");
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_term();
        test_read_stall();
        test_timeout();
        test_random();
        test_err_sat();
        test_checksum();
        test_reset_mid_resp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
